// File: rtl/reel_stop_sequencer.sv
// reel_stop_sequencer
//
// Game controller for a four-reel random generator bank. A spin request
// (rising edge of spin) charges one credit and starts all reels. A stop
// request (rising edge of stop_req) stops the reels left to right, one every
// GAP_CYCLES. The stop never lands before the reels have spun for MIN_SPIN
// cycles. Each reel's live value is latched as it stops. The final
// combination is then evaluated and any payout is added to a saturating
// credit counter.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   spin       in   debounced spin button level
//   stop_req   in   debounced stop button level
//   reel_val   in   live generator outputs, [3:0]=reel0 ... [15:12]=reel3
//   reel_run   out  per-reel run enable (1 = free-running)
//   result     out  latched stopped values, same packing as reel_val
//   credits    out  current credit balance
//   win_amount out  payout of the last completed spin
//   win_flag   out  last completed spin paid more than zero
//   busy       out  high from spin acceptance until evaluation completes
//   done       out  one-cycle pulse when evaluation completes

module reel_stop_sequencer #(
    parameter int unsigned GAP_CYCLES    = 100,
    parameter int unsigned MIN_SPIN      = 50,
    parameter int unsigned CREDIT_W      = 8,
    parameter int unsigned START_CREDITS = 10,
    parameter int unsigned WIN3_PAY      = 5,
    parameter int unsigned WIN4_PAY      = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spin,
    input  logic                stop_req,
    input  logic [15:0]         reel_val,
    output logic [3:0]          reel_run,
    output logic [15:0]         result,
    output logic [CREDIT_W-1:0] credits,
    output logic [CREDIT_W-1:0] win_amount,
    output logic                win_flag,
    output logic                busy,
    output logic                done
);

    localparam int unsigned SPIN_W = $clog2(MIN_SPIN + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [SPIN_W-1:0]   SPIN_LAST = SPIN_W'(MIN_SPIN - 1);
    localparam logic [SPIN_W-1:0]   SPIN_MAX  = SPIN_W'(MIN_SPIN);
    localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] CRED_INIT = CREDIT_W'(START_CREDITS);
    localparam logic [CREDIT_W-1:0] PAY3      = CREDIT_W'(WIN3_PAY);
    localparam logic [CREDIT_W-1:0] PAY4      = CREDIT_W'(WIN4_PAY);
    localparam logic [CREDIT_W:0]   CRED_SAT  = {1'b0, {CREDIT_W{1'b1}}};

    typedef enum logic [1:0] {StIdle, StSpin, StStopping, StEval} state_e;

    state_e              state_q;
    logic                spin_prev_q;
    logic                stop_prev_q;
    logic                stop_pending_q;
    logic [SPIN_W-1:0]   spin_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [1:0]          reel_idx_q;

    logic                spin_edge;
    logic                stop_edge;
    logic                spin_due;
    logic [CREDIT_W-1:0] pay;
    logic [CREDIT_W:0]   cred_sum;
    logic [CREDIT_W-1:0] cred_paid;

    assign spin_edge = spin & ~spin_prev_q;
    assign stop_edge = stop_req & ~stop_prev_q;

    // True at the edge where the spin counter reaches MIN_SPIN, and after.
    assign spin_due = (spin_cnt_q >= SPIN_LAST);

    // Payout from the latched combination.
    always_comb begin
        logic [3:0] n0, n1, n2, n3;
        logic e01, e02, e03, e12, e13, e23;
        logic all4, three;
        n0 = result[3:0];
        n1 = result[7:4];
        n2 = result[11:8];
        n3 = result[15:12];
        e01 = (n0 == n1);
        e02 = (n0 == n2);
        e03 = (n0 == n3);
        e12 = (n1 == n2);
        e13 = (n1 == n3);
        e23 = (n2 == n3);
        all4 = e01 & e02 & e03;
        // Exactly one reel differs from the other three.
        three = (e01 & e02 & ~e03) |
                (e01 & e03 & ~e02) |
                (e02 & e03 & ~e01) |
                (e12 & e13 & ~e01);
        pay = '0;
        if (all4) begin
            pay = PAY4;
        end else if (three) begin
            pay = PAY3;
        end
        // e23 is implied by the other terms; keep it referenced for clarity.
        if (all4 && !e23) begin
            pay = '0;
        end
    end

    // One extra bit of headroom, then clamp to the counter's maximum.
    assign cred_sum  = {1'b0, credits} + {1'b0, pay};
    assign cred_paid = (cred_sum > CRED_SAT) ? {CREDIT_W{1'b1}} : cred_sum[CREDIT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            spin_prev_q    <= 1'b0;
            stop_prev_q    <= 1'b0;
            stop_pending_q <= 1'b0;
            spin_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            reel_idx_q     <= 2'd0;
            reel_run       <= 4'h0;
            result         <= 16'h0000;
            credits        <= CRED_INIT;
            win_amount     <= '0;
            win_flag       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            spin_prev_q <= spin;
            stop_prev_q <= stop_req;
            done        <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (spin_edge && (credits != '0)) begin
                        reel_run       <= 4'hF;
                        credits        <= credits - CREDIT_W'(1);
                        busy           <= 1'b1;
                        win_flag       <= 1'b0;
                        win_amount     <= '0;
                        spin_cnt_q     <= '0;
                        stop_pending_q <= 1'b0;
                        state_q        <= StSpin;
                    end
                end

                StSpin: begin
                    if (spin_cnt_q != SPIN_MAX) begin
                        spin_cnt_q <= spin_cnt_q + SPIN_W'(1);
                    end
                    if ((stop_edge || stop_pending_q) && spin_due) begin
                        reel_run[0]    <= 1'b0;
                        result[3:0]    <= reel_val[3:0];
                        gap_cnt_q      <= '0;
                        reel_idx_q     <= 2'd1;
                        stop_pending_q <= 1'b0;
                        state_q        <= StStopping;
                    end else if (stop_edge) begin
                        // Early stop: remember it until the minimum spin time elapses.
                        stop_pending_q <= 1'b1;
                    end
                end

                StStopping: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        reel_run[reel_idx_q]               <= 1'b0;
                        result[{reel_idx_q, 2'b00} +: 4]   <= reel_val[{reel_idx_q, 2'b00} +: 4];
                        gap_cnt_q                          <= '0;
                        reel_idx_q                         <= reel_idx_q + 2'd1;
                        if (reel_idx_q == 2'd3) begin
                            state_q <= StEval;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end

                StEval: begin
                    credits    <= cred_paid;
                    win_amount <= pay;
                    win_flag   <= (pay != '0);
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state_q    <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reel_stop_sequencer.sv
module tb_reel_stop_sequencer;

    localparam int G = 4;
    localparam int M = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        spin;
    logic        stop_req;
    logic [15:0] reel_val;
    logic [3:0]  reel_run;
    logic [15:0] result;
    logic [7:0]  credits;
    logic [7:0]  win_amount;
    logic        win_flag;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mcred;
    logic [15:0] hist [0:63];

    always #5 clk = ~clk;

    reel_stop_sequencer #(
        .GAP_CYCLES    (G),
        .MIN_SPIN      (M),
        .CREDIT_W      (8),
        .START_CREDITS (10),
        .WIN3_PAY      (5),
        .WIN4_PAY      (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spin       (spin),
        .stop_req   (stop_req),
        .reel_val   (reel_val),
        .reel_run   (reel_run),
        .result     (result),
        .credits    (credits),
        .win_amount (win_amount),
        .win_flag   (win_flag),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Payout from the most frequent symbol count among the four reels.
    function automatic int pay_of(input logic [15:0] r);
        int maxc;
        int cnt;
        maxc = 0;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            for (int j = 0; j < 4; j++) begin
                if (r[4*i +: 4] == r[4*j +: 4]) cnt++;
            end
            if (cnt > maxc) maxc = cnt;
        end
        if (maxc == 4) return 20;
        if (maxc == 3) return 5;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag, input int cred);
        check_eq({tag, "_run"}, reel_run, 4'h0);
        check_eq({tag, "_result"}, result, 16'h0);
        check_eq({tag, "_credits"}, credits, cred);
        check_eq({tag, "_win_amount"}, win_amount, 0);
        check_eq({tag, "_win_flag"}, win_flag, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        spin     = 1'b0;
        stop_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        mcred = 10;
        tick();
    endtask

    // One full spin. d: stop edge offset from acceptance edge T.
    // mode 0: reel_val forced to fv; 1: random with frequent matches; 2: fully random.
    task automatic run_spin(input int d, input int mode, input logic [15:0] fv,
                            input int spin_hold, input int n_idle, input bit do_rst);
        int          s;
        int          dn;
        int          pay;
        int          expc;
        logic [15:0] exp_res;
        logic [3:0]  exp_run;
        logic [3:0]  b;

        repeat (n_idle) tick();
        spin     = 1'b1;
        stop_req = 1'b0;
        tick();
        check_eq("accept_busy", busy, 1);
        check_eq("accept_run", reel_run, 4'hF);
        check_eq("accept_credits", credits, mcred - 1);
        check_eq("accept_win_flag", win_flag, 0);
        check_eq("accept_win_amount", win_amount, 0);
        mcred = mcred - 1;

        s  = (d <= M) ? M : d;
        dn = s + 3 * G + 1;
        for (int c = 1; c <= dn; c++) begin
            if (mode == 0) begin
                reel_val = fv;
            end else if (mode == 1) begin
                b = 4'($urandom_range(0, 14));
                for (int k = 0; k < 4; k++) reel_val[4*k +: 4] = b + 4'($urandom_range(0, 1));
            end else begin
                reel_val = 16'($urandom);
            end
            hist[c] = reel_val;
            if (c == spin_hold) spin = 1'b0;
            if (spin_hold < 4 && c == 4) spin = 1'b1;
            if (spin_hold < 4 && c == 5) spin = 1'b0;
            if (c == d) stop_req = 1'b1;
            if (c == d + 2) stop_req = 1'b0;
            tick();

            for (int k = 0; k < 4; k++) exp_run[k] = (c >= s + k * G) ? 1'b0 : 1'b1;
            check_eq("run", reel_run, exp_run);
            check_eq("busy", busy, (c < dn) ? 1 : 0);
            check_eq("done", done, (c == dn) ? 1 : 0);

            if (do_rst && c == s + G + 1) begin
                reset = 1'b1;
                #1;
                check_reset_state("mid_reset", 10);
                reset    = 1'b0;
                spin     = 1'b0;
                stop_req = 1'b0;
                mcred    = 10;
                return;
            end
        end

        for (int k = 0; k < 4; k++) exp_res[4*k +: 4] = hist[s + k * G][4*k +: 4];
        pay  = pay_of(exp_res);
        expc = mcred + pay;
        if (expc > 255) expc = 255;
        check_eq("result", result, exp_res);
        check_eq("win_amount", win_amount, pay);
        check_eq("win_flag", win_flag, (pay != 0) ? 1 : 0);
        check_eq("credits", credits, expc);
        mcred = expc;

        if (spin_hold > dn) begin
            repeat (3) begin
                tick();
                check_eq("held_busy", busy, 0);
                check_eq("held_credits", credits, mcred);
            end
            spin = 1'b0;
        end
        stop_req = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        spin     = 1'b0;
        stop_req = 1'b0;
        reel_val = 16'h0;
        mcred    = 10;
        #1;
        check_reset_state("reset", 10);
        do_reset();
        check_reset_state("idle", 10);

        // Held spin level, early stop at T+2.
        run_spin(2, 1, 16'h0, 1000, 2, 1'b0);
        run_spin(3, 0, 16'h7777, 2, 2, 1'b0);
        run_spin(M, 0, 16'h3533, 2, 2, 1'b0);
        run_spin(M + 3, 0, 16'h1234, 2, 2, 1'b0);
        // Spin edge in the cycle right after done.
        run_spin(1, 1, 16'h0, 2, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if (mcred == 0) do_reset();
            run_spin($urandom_range(1, 12), $urandom_range(1, 2), 16'h0, 2,
                     $urandom_range(0, 2), 1'b0);
        end

        // Reset after reel1 stops, then a normal spin.
        if (mcred == 0) do_reset();
        run_spin(5, 2, 16'h0, 2, 2, 1'b1);
        run_spin(4, 0, 16'h7777, 2, 2, 1'b0);
        check_eq("after_reset_credits", credits, 29);

        // Saturation: 10 -> 238 -> 250 -> 255.
        do_reset();
        for (int i = 0; i < 12; i++) run_spin($urandom_range(1, 12), 0, 16'h7777, 2, 2, 1'b0);
        for (int i = 0; i < 3; i++) run_spin($urandom_range(1, 12), 0, 16'h3533, 2, 2, 1'b0);
        check_eq("cred_250", credits, 250);
        run_spin(2, 0, 16'h7777, 2, 2, 1'b0);
        check_eq("cred_sat", credits, 255);
        run_spin(9, 0, 16'h7777, 2, 2, 1'b0);
        check_eq("cred_sat2", credits, 255);

        // Drain to zero, then a spin must be ignored.
        do_reset();
        for (int i = 0; i < 10; i++) run_spin($urandom_range(1, 12), 0, 16'h1234, 2, 2, 1'b0);
        check_eq("cred_zero", credits, 0);
        tick();
        spin = 1'b1;
        repeat (4) begin
            tick();
            check_eq("zero_busy", busy, 0);
            check_eq("zero_run", reel_run, 4'h0);
            check_eq("zero_credits", credits, 0);
            check_eq("zero_done", done, 0);
        end
        spin = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
